dmem_ctrl: RTL and testbench

Data-memory access controller between the pipelined MIPS MEM stage and a variable-latency data memory port.
- Converts MEM-stage load/store requests (byte/half/word, signed/unsigned loads) into word-aligned memory transactions with byte enables.
- Stalls the pipeline until the memory responds.
- Returns lane-steered, sign- or zero-extended load data.
- Flags misaligned accesses and memory timeouts.

---
 rtl/mips_mem_pkg.sv | 37 +++
 rtl/dmem_lane.sv | 44 ++++
 rtl/dmem_ctrl.sv | 178 +++++++++++++++++
 tb/tb_dmem_ctrl.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_mem_pkg.sv
// Shared types and helpers for the MIPS data-memory access controller.
package mips_mem_pkg;

    typedef enum logic [1:0] {
        SZ_NONE = 2'b00,
        SZ_BYTE = 2'b01,
        SZ_HALF = 2'b10,
        SZ_WORD = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_e;

    function automatic logic [3:0] be_of(input size_e size, input logic [1:0] lo);
        logic [3:0] be;
        case (size)
            SZ_BYTE: be = 4'b0001 << lo;
            SZ_HALF: be = lo[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    function automatic logic is_misaligned(input size_e size, input logic [1:0] lo);
        logic mis;
        case (size)
            SZ_HALF: mis = lo[0];
            SZ_BYTE: mis = 1'b0;
            default: mis = (lo != 2'b00);
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/dmem_lane.sv
// Combinational store-data lane replication and load-data lane extraction/extension.
module dmem_lane
    import mips_mem_pkg::*;
(
    input  logic [1:0]  st_size,
    input  logic [31:0] st_wdata,
    output logic [31:0] st_rep,
    input  logic [1:0]  ld_size,
    input  logic [1:0]  ld_lo,
    input  logic        ld_unsigned,
    input  logic [31:0] ld_word,
    output logic [31:0] ld_data
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    always_comb begin
        case (size_e'(st_size))
            SZ_BYTE: st_rep = {4{st_wdata[7:0]}};
            SZ_HALF: st_rep = {2{st_wdata[15:0]}};
            default: st_rep = st_wdata;
        endcase
    end

    always_comb begin
        ld_byte = ld_word[7:0];
        case (ld_lo)
            2'd0: ld_byte = ld_word[7:0];
            2'd1: ld_byte = ld_word[15:8];
            2'd2: ld_byte = ld_word[23:16];
            2'd3: ld_byte = ld_word[31:24];
            default: ld_byte = ld_word[7:0];
        endcase
        ld_half = ld_lo[1] ? ld_word[31:16] : ld_word[15:0];

        case (size_e'(ld_size))
            SZ_BYTE: ld_data = {{24{~ld_unsigned & ld_byte[7]}}, ld_byte};
            SZ_HALF: ld_data = {{16{~ld_unsigned & ld_half[15]}}, ld_half};
            default: ld_data = ld_word;
        endcase
    end

endmodule

// File: rtl/dmem_ctrl.sv
// MEM-stage data-memory controller: aligns requests, stalls until the memory
// responds or times out, and returns extended load data.
module dmem_ctrl
    import mips_mem_pkg::*;
#(
    parameter int unsigned WAIT_MAX = 16,
    parameter int unsigned ADDR_W   = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mem_read,
    input  logic [1:0]        memwrite,
    input  logic [1:0]        load_size,
    input  logic              load_unsigned,
    input  logic [ADDR_W-1:0] dataadr,
    input  logic [31:0]       writedata,
    output logic              stall,
    output logic [31:0]       rdata,
    output logic              rvalid,
    output logic              misalign,
    output logic              bus_err,
    output logic              dm_req,
    output logic              dm_we,
    output logic [3:0]        dm_be,
    output logic [ADDR_W-1:0] dm_addr,
    output logic [31:0]       dm_wdata,
    input  logic              dm_ready,
    input  logic [31:0]       dm_rdata
);

    localparam logic [7:0] WAIT_LIM = 8'(WAIT_MAX);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [1:0]        lo_q, lo_d;
    size_e             size_q, size_d;
    logic              we_q, we_d;
    logic              uns_q, uns_d;
    logic [3:0]        be_q, be_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [7:0]        cnt_q, cnt_d;
    logic              err_q, err_d;
    logic [31:0]       rdata_q, rdata_d;

    logic        req_st;
    logic        act;
    size_e       req_size;
    logic        req_mis;
    logic [31:0] st_rep;
    logic [31:0] ld_data;
    logic [7:0]  cnt_inc;

    assign req_st   = (memwrite != 2'b00);
    assign act      = mem_read | req_st;
    assign req_size = req_st ? size_e'(memwrite)
                    : ((load_size == 2'b00) ? SZ_WORD : size_e'(load_size));
    assign req_mis  = is_misaligned(req_size, dataadr[1:0]);
    assign cnt_inc  = cnt_q + 8'd1;

    dmem_lane u_lane (
        .st_size     (req_size),
        .st_wdata    (writedata),
        .st_rep      (st_rep),
        .ld_size     (size_q),
        .ld_lo       (lo_q),
        .ld_unsigned (uns_q),
        .ld_word     (dm_rdata),
        .ld_data     (ld_data)
    );

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        lo_d     = lo_q;
        size_d   = size_q;
        we_d     = we_q;
        uns_d    = uns_q;
        be_d     = be_q;
        wdata_d  = wdata_q;
        cnt_d    = cnt_q;
        err_d    = err_q;
        rdata_d  = rdata_q;
        stall    = 1'b0;
        dm_req   = 1'b0;
        misalign = 1'b0;
        rvalid   = 1'b0;
        bus_err  = 1'b0;

        case (state_q)
            IDLE: begin
                if (act) begin
                    if (req_mis) begin
                        misalign = 1'b1;
                    end else begin
                        stall   = 1'b1;
                        addr_d  = {dataadr[ADDR_W-1:2], 2'b00};
                        lo_d    = dataadr[1:0];
                        size_d  = req_size;
                        we_d    = req_st;
                        uns_d   = load_unsigned;
                        be_d    = be_of(req_size, dataadr[1:0]);
                        wdata_d = st_rep;
                        cnt_d   = '0;
                        err_d   = 1'b0;
                        state_d = ACCESS;
                    end
                end
            end
            ACCESS: begin
                dm_req = 1'b1;
                stall  = 1'b1;
                cnt_d  = cnt_inc;
                if (dm_ready) begin
                    err_d   = 1'b0;
                    state_d = RESP;
                    if (!we_q) begin
                        rdata_d = ld_data;
                    end
                end else if (cnt_inc == WAIT_LIM) begin
                    err_d   = 1'b1;
                    state_d = RESP;
                    if (!we_q) begin
                        rdata_d = '0;
                    end
                end
            end
            RESP: begin
                rvalid  = ~we_q;
                bus_err = err_q;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // IDLE decodes live inputs, so keep the handshake quiet while reset is held
        if (!reset) begin
            stall    = 1'b0;
            misalign = 1'b0;
        end
        dm_we = dm_req & we_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            lo_q    <= '0;
            size_q  <= SZ_NONE;
            we_q    <= 1'b0;
            uns_q   <= 1'b0;
            be_q    <= '0;
            wdata_q <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            lo_q    <= lo_d;
            size_q  <= size_d;
            we_q    <= we_d;
            uns_q   <= uns_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
    end

    assign dm_be    = be_q;
    assign dm_addr  = addr_q;
    assign dm_wdata = wdata_q;
    assign rdata    = rdata_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Self-checking bench for dmem_ctrl: directed table, reset sequences and
// randomized traffic against a byte-level memory model.
module tb_dmem_ctrl;

    localparam int unsigned WAIT_MAX = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_read;
    logic [1:0]  memwrite;
    logic [1:0]  load_size;
    logic        load_unsigned;
    logic [31:0] dataadr;
    logic [31:0] writedata;
    logic        stall;
    logic [31:0] rdata;
    logic        rvalid;
    logic        misalign;
    logic        bus_err;
    logic        dm_req;
    logic        dm_we;
    logic [3:0]  dm_be;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic        dm_ready;
    logic [31:0] dm_rdata;

    always #5 clk = ~clk;

    dmem_ctrl #(.WAIT_MAX(WAIT_MAX), .ADDR_W(32)) dut (
        .clk           (clk),
        .reset         (reset),
        .mem_read      (mem_read),
        .memwrite      (memwrite),
        .load_size     (load_size),
        .load_unsigned (load_unsigned),
        .dataadr       (dataadr),
        .writedata     (writedata),
        .stall         (stall),
        .rdata         (rdata),
        .rvalid        (rvalid),
        .misalign      (misalign),
        .bus_err       (bus_err),
        .dm_req        (dm_req),
        .dm_we         (dm_we),
        .dm_be         (dm_be),
        .dm_addr       (dm_addr),
        .dm_wdata      (dm_wdata),
        .dm_ready      (dm_ready),
        .dm_rdata      (dm_rdata)
    );

    int          n_vec = 0;
    int          n_miss = 0;
    logic [31:0] last_rdata;
    logic [31:0] mem [16];

    typedef struct {
        string       tag;
        logic        rd;
        logic [1:0]  mw;
        logic [1:0]  ls;
        logic        uns;
        logic [31:0] adr;
        logic [31:0] wd;
        logic [31:0] mword;
        int          lat;
        logic        mis;
        logic [3:0]  be;
        logic [31:0] ewd;
        logic        err;
        logic [31:0] erd;
    } vec_t;

    vec_t tbl [16];

    task automatic chk32(input string tag, input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %0s.%0s: got %h expected %h", tag, name, act, exp);
        end
    endtask

    task automatic chk1(input string tag, input string name, input logic act, input logic exp);
        chk32(tag, name, 32'(act), 32'(exp));
    endtask

    // Reference model: byte-level view of sizes, lanes and extension.
    function automatic int nbytes(input logic [1:0] sz);
        if (sz == 2'd1) return 1;
        if (sz == 2'd2) return 2;
        return 4;
    endfunction

    function automatic logic [3:0] m_be(input int n, input int off);
        logic [3:0] r;
        for (int k = 0; k < 4; k++) r[k] = (k >= off) && (k < off + n);
        return r;
    endfunction

    function automatic logic [31:0] m_wd(input int n, input logic [31:0] wd);
        logic [31:0] r;
        for (int k = 0; k < 4; k++) r[8*k +: 8] = wd[8*(k % n) +: 8];
        return r;
    endfunction

    function automatic logic [31:0] m_ld(input int n, input int off, input logic uns, input logic [31:0] word);
        logic [31:0] v;
        v = '0;
        for (int i = 0; i < n; i++) v[8*i +: 8] = word[8*(off + i) +: 8];
        if (!uns && n < 4 && v[8*n - 1]) begin
            for (int b = 8 * n; b < 32; b++) v[b] = 1'b1;
        end
        return v;
    endfunction

    task automatic idle_inputs();
        mem_read      = 1'b0;
        memwrite      = 2'b00;
        load_size     = 2'b00;
        load_unsigned = 1'b0;
        dataadr       = $urandom;
        writedata     = $urandom;
    endtask

    task automatic do_access(input string tag, input logic rd, input logic [1:0] mw, input logic [1:0] ls,
                             input logic uns, input logic [31:0] adr, input logic [31:0] wd,
                             input logic [31:0] mword, input int lat, input logic exp_mis,
                             input logic [3:0] exp_be, input logic [31:0] exp_wd, input logic exp_err,
                             input logic [31:0] exp_rdata);
        logic st;
        st = (mw != 2'b00);
        mem_read = rd; memwrite = mw; load_size = ls; load_unsigned = uns;
        dataadr = adr; writedata = wd; dm_ready = 1'b0; dm_rdata = $urandom;
        #1;
        if (exp_mis) begin
            chk1(tag, "misalign", misalign, 1'b1);
            chk1(tag, "mis_stall", stall, 1'b0);
            chk1(tag, "mis_req", dm_req, 1'b0);
            @(posedge clk); #1;
            idle_inputs();
            #1;
            chk1(tag, "mis_after", misalign, 1'b0);
            chk1(tag, "mis_req2", dm_req, 1'b0);
            chk32(tag, "mis_rdata", rdata, last_rdata);
            return;
        end
        chk1(tag, "misalign0", misalign, 1'b0);
        chk1(tag, "idle_stall", stall, 1'b1);
        chk1(tag, "idle_req", dm_req, 1'b0);
        @(posedge clk); #1;
        for (int c = 1; c <= int'(WAIT_MAX); c++) begin
            dm_ready = (c == lat);
            dm_rdata = (c == lat) ? mword : $urandom;
            #1;
            chk1(tag, "req", dm_req, 1'b1);
            chk1(tag, "stall", stall, 1'b1);
            chk1(tag, "we", dm_we, st);
            chk32(tag, "addr", dm_addr, {adr[31:2], 2'b00});
            chk32(tag, "be", 32'(dm_be), 32'(exp_be));
            if (st) chk32(tag, "wdata", dm_wdata, exp_wd);
            @(posedge clk); #1;
            if (c == lat) break;
        end
        // RESP: a stray ready and a fresh request must both be ignored
        dm_ready = 1'b1; dm_rdata = $urandom;
        mem_read = 1'b1; memwrite = 2'b00; load_size = 2'b11; dataadr = {adr[31:2], 2'b00};
        #1;
        chk1(tag, "resp_stall", stall, 1'b0);
        chk1(tag, "resp_req", dm_req, 1'b0);
        chk1(tag, "rvalid", rvalid, !st);
        chk1(tag, "bus_err", bus_err, exp_err);
        if (!st) last_rdata = exp_rdata;
        chk32(tag, "rdata", rdata, last_rdata);
        @(posedge clk); #1;
        idle_inputs();
        dm_ready = 1'b0;
        #1;
        chk1(tag, "post_rvalid", rvalid, 1'b0);
        chk1(tag, "post_err", bus_err, 1'b0);
        chk1(tag, "post_req", dm_req, 1'b0);
        chk1(tag, "post_stall", stall, 1'b0);
        chk32(tag, "post_rdata", rdata, last_rdata);
    endtask

    initial begin
        tbl[0]  = '{"lb_80",    1'b1, 2'd0, 2'd1, 1'b0, 32'd80,   32'h0,        32'h000000FF, 2,  1'b0, 4'b0001, 32'h0,        1'b0, 32'hFFFFFFFF};
        tbl[1]  = '{"lbu_81",   1'b1, 2'd0, 2'd1, 1'b1, 32'd81,   32'h0,        32'h0000FF00, 1,  1'b0, 4'b0010, 32'h0,        1'b0, 32'h000000FF};
        tbl[2]  = '{"sh_86",    1'b0, 2'd2, 2'd0, 1'b0, 32'd86,   32'h1234ABCD, 32'h0,        3,  1'b0, 4'b1100, 32'hABCDABCD, 1'b0, 32'h0};
        tbl[3]  = '{"sw_82",    1'b0, 2'd3, 2'd0, 1'b0, 32'd82,   32'hDEADBEEF, 32'h0,        1,  1'b1, 4'b0000, 32'h0,        1'b0, 32'h0};
        tbl[4]  = '{"lw_to",    1'b1, 2'd0, 2'd3, 1'b0, 32'd100,  32'h0,        32'h0,        0,  1'b0, 4'b1111, 32'h0,        1'b1, 32'h0};
        tbl[5]  = '{"lhu_42",   1'b1, 2'd0, 2'd2, 1'b1, 32'h42,   32'h0,        32'h80011234, 1,  1'b0, 4'b1100, 32'h0,        1'b0, 32'h00008001};
        tbl[6]  = '{"sb_03",    1'b0, 2'd1, 2'd0, 1'b0, 32'h3,    32'h00000055, 32'h0,        2,  1'b0, 4'b1000, 32'h55555555, 1'b0, 32'h0};
        tbl[7]  = '{"lh_41",    1'b1, 2'd0, 2'd2, 1'b0, 32'h41,   32'h0,        32'h0,        1,  1'b1, 4'b0000, 32'h0,        1'b0, 32'h0};
        tbl[8]  = '{"lw_10",    1'b1, 2'd0, 2'd3, 1'b0, 32'h10,   32'h0,        32'hDEADBEEF, 4,  1'b0, 4'b1111, 32'h0,        1'b0, 32'hDEADBEEF};
        tbl[9]  = '{"st_prio",  1'b1, 2'd1, 2'd3, 1'b0, 32'h21,   32'h1234567A, 32'h0,        1,  1'b0, 4'b0010, 32'h7A7A7A7A, 1'b0, 32'h0};
        tbl[10] = '{"ls00_22",  1'b1, 2'd0, 2'd0, 1'b0, 32'h22,   32'h0,        32'h0,        1,  1'b1, 4'b0000, 32'h0,        1'b0, 32'h0};
        tbl[11] = '{"ls00_24",  1'b1, 2'd0, 2'd0, 1'b0, 32'h24,   32'h0,        32'h12345678, 1,  1'b0, 4'b1111, 32'h0,        1'b0, 32'h12345678};
        tbl[12] = '{"lw_edge",  1'b1, 2'd0, 2'd3, 1'b0, 32'h30,   32'h0,        32'hCAFEF00D, 16, 1'b0, 4'b1111, 32'h0,        1'b0, 32'hCAFEF00D};
        tbl[13] = '{"lb_pos",   1'b1, 2'd0, 2'd1, 1'b0, 32'h2,    32'h0,        32'h007F0000, 1,  1'b0, 4'b0100, 32'h0,        1'b0, 32'h0000007F};
        tbl[14] = '{"lh_neg",   1'b1, 2'd0, 2'd2, 1'b0, 32'h40,   32'h0,        32'h1234F00F, 1,  1'b0, 4'b0011, 32'h0,        1'b0, 32'hFFFFF00F};
        tbl[15] = '{"sw_08",    1'b0, 2'd3, 2'd0, 1'b0, 32'h8,    32'hA5A50F0F, 32'h0,        1,  1'b0, 4'b1111, 32'hA5A50F0F, 1'b0, 32'h0};

        for (int i = 0; i < 16; i++) mem[i] = $urandom;

        // Reset state, with a live request on the inputs
        reset = 1'b0;
        idle_inputs();
        mem_read = 1'b1; load_size = 2'b11; dataadr = 32'h0;
        dm_ready = 1'b0; dm_rdata = '0;
        #3;
        chk1("reset", "stall", stall, 1'b0);
        chk1("reset", "req", dm_req, 1'b0);
        chk1("reset", "we", dm_we, 1'b0);
        chk1("reset", "rvalid", rvalid, 1'b0);
        chk1("reset", "misalign", misalign, 1'b0);
        chk1("reset", "bus_err", bus_err, 1'b0);
        chk32("reset", "be", 32'(dm_be), 32'h0);
        chk32("reset", "addr", dm_addr, 32'h0);
        chk32("reset", "wdata", dm_wdata, 32'h0);
        chk32("reset", "rdata", rdata, 32'h0);
        idle_inputs();
        last_rdata = '0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 16; i++) begin
            do_access(tbl[i].tag, tbl[i].rd, tbl[i].mw, tbl[i].ls, tbl[i].uns, tbl[i].adr, tbl[i].wd,
                      tbl[i].mword, tbl[i].lat, tbl[i].mis, tbl[i].be, tbl[i].ewd, tbl[i].err, tbl[i].erd);
        end

        // Reset asserted mid-ACCESS, request inputs still active
        mem_read = 1'b1; memwrite = 2'b00; load_size = 2'b11; dataadr = 32'h60;
        #1;
        chk1("rst_mid", "idle_stall", stall, 1'b1);
        @(posedge clk); #1;
        chk1("rst_mid", "req_before", dm_req, 1'b1);
        #2;
        reset = 1'b0;
        #1;
        chk1("rst_mid", "req", dm_req, 1'b0);
        chk1("rst_mid", "stall", stall, 1'b0);
        chk32("rst_mid", "addr", dm_addr, 32'h0);
        chk32("rst_mid", "rdata", rdata, 32'h0);
        last_rdata = '0;
        idle_inputs();
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        do_access("lh_42", 1'b1, 2'd0, 2'd2, 1'b0, 32'h42, 32'h0, 32'h80015A5A, 2,
                  1'b0, 4'b1100, 32'h0, 1'b0, 32'hFFFF8001);

        // Randomized traffic against the memory model
        for (int it = 0; it < 80; it++) begin
            logic [3:0]  widx;
            int          off, n, lat, r;
            logic        rd, uns, st, mis, err;
            logic [1:0]  mw, ls, sz;
            logic [31:0] adr, wd, ewd, erd;
            logic [3:0]  ebe;
            widx = 4'($urandom_range(0, 15));
            off  = $urandom_range(0, 3);
            adr  = 32'(int'(widx) * 4 + off);
            rd   = 1'($urandom_range(0, 1));
            mw   = 2'($urandom_range(0, 3));
            if (!rd && mw == 2'b00) rd = 1'b1;
            ls   = 2'($urandom_range(0, 3));
            uns  = 1'($urandom_range(0, 1));
            wd   = $urandom;
            st   = (mw != 2'b00);
            sz   = st ? mw : ((ls == 2'b00) ? 2'd3 : ls);
            n    = nbytes(sz);
            mis  = (off % n) != 0;
            r    = $urandom_range(0, 9);
            lat  = (r == 0) ? 0 : (r == 1) ? int'(WAIT_MAX) : $urandom_range(1, 4);
            err  = (lat == 0);
            ebe  = m_be(n, off);
            ewd  = st ? m_wd(n, wd) : 32'h0;
            erd  = (st || err) ? 32'h0 : m_ld(n, off, uns, mem[widx]);
            do_access($sformatf("rnd%0d", it), rd, mw, ls, uns, adr, wd, mem[widx], lat,
                      mis, ebe, ewd, err, erd);
            if (st && !mis && !err) begin
                for (int k = 0; k < 4; k++) begin
                    if (ebe[k]) mem[widx][8*k +: 8] = ewd[8*k +: 8];
                end
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
